// File: rtl/ysyx_22040759_if_axi_bridge_pkg.sv
// ============================================================================
// Module : ysyx_22040759_if_axi_bridge_pkg
// Brief  : Shared size/response/burst codes, bridge FSM encodings, lane helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ysyx_22040759_if_axi_bridge_pkg;

   localparam logic [1:0] SIZE_W      = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam int         TAG_W       = 61;

   typedef logic [1:0] ifb_state_t;
   localparam ifb_state_t S_IDLE = 2'd0;
   localparam ifb_state_t S_AR   = 2'd1;
   localparam ifb_state_t S_R    = 2'd2;
   localparam ifb_state_t S_RESP = 2'd3;

   // Pick the 32-bit instruction out of a 64-bit beat using address bit 2.
   function automatic logic [31:0] lane_sel(input logic hi, input logic [63:0] beat);
      return hi ? beat[63:32] : beat[31:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040759_if_axi_bridge_linebuf.sv
// ============================================================================
// Module : ysyx_22040759_ifb_linebuf
// Brief  : One-entry fetch line buffer (tag compare + 64-bit beat storage).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040759_ifb_linebuf
   import ysyx_22040759_if_axi_bridge_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [TAG_W-1:0] i_lookup_tag,
   output logic             o_hit,
   output logic [63:0]      o_data,
   input  logic             i_fill,
   input  logic [TAG_W-1:0] i_fill_tag,
   input  logic [63:0]      i_fill_data,
   input  logic             i_inval
);

   logic             r_valid;
   logic [TAG_W-1:0] r_tag;
   logic [63:0]      r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_tag   <= i_fill_tag;
         r_data  <= i_fill_data;
      end else if (i_inval) begin
         r_valid <= 1'b0;
      end
   end

   assign o_hit  = r_valid && (r_tag == i_lookup_tag);
   assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040759_if_axi_bridge.sv
// ============================================================================
// Module : ysyx_22040759_if_axi_bridge
// Brief  : IF fetch handshake to single-beat AXI4 read bridge.
//          Optional line buffer: define YSYX_22040759_IFB_LINEBUF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040759_if_axi_bridge
   import ysyx_22040759_if_axi_bridge_pkg::*;
#(
   parameter int              ID_W   = 4,
   parameter logic [ID_W-1:0] AXI_ID = '0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [63:0]     inst_addr,
   input  logic [1:0]      if_size,
   output logic            if_ready,
   output logic [63:0]     if_data_read,
   output logic [1:0]      if_resp,
   output logic            axi_ar_valid,
   input  logic            axi_ar_ready,
   output logic [63:0]     axi_ar_addr,
   output logic [ID_W-1:0] axi_ar_id,
   output logic [7:0]      axi_ar_len,
   output logic [2:0]      axi_ar_size,
   output logic [1:0]      axi_ar_burst,
   input  logic            axi_r_valid,
   output logic            axi_r_ready,
   input  logic [63:0]     axi_r_data,
   input  logic [1:0]      axi_r_resp,
   input  logic            axi_r_last,
   input  logic [ID_W-1:0] axi_r_id
);

   ifb_state_t  r_state;
   ifb_state_t  w_state_nxt;
   logic [63:0] r_addr;
   logic [1:0]  r_size;
   logic        r_err;
   logic        r_ar_valid;
   logic        r_r_ready;
   logic        r_if_ready;
   logic [63:0] r_if_data;
   logic [1:0]  r_if_resp;
   logic        w_ar_valid_nxt;
   logic        w_r_ready_nxt;
   logic        w_if_ready_nxt;

   logic        w_misaligned;
   logic        w_idle_req;
   logic        w_mis_accept;
   logic        w_hit_accept;
   logic        w_beat;
   logic        w_beat_err;
   logic        w_err_tot;
   logic        w_done_rd;
   logic        w_lb_hit;
   logic [63:0] w_lb_data;

   assign w_misaligned = |inst_addr[1:0];
   assign w_idle_req   = (r_state == S_IDLE) && if_valid;
   assign w_mis_accept = w_idle_req && w_misaligned;
   assign w_hit_accept = w_idle_req && !w_misaligned && w_lb_hit;
   assign w_beat       = (r_state == S_R) && axi_r_valid;
   assign w_beat_err   = (axi_r_resp != RESP_OKAY) || (axi_r_id != AXI_ID) || !axi_r_last;
   assign w_err_tot    = r_err || w_beat_err;
   assign w_done_rd    = w_beat && axi_r_last;

`ifdef YSYX_22040759_IFB_LINEBUF_EN
   ysyx_22040759_ifb_linebuf u_linebuf (
      .clk          (clk),
      .rst          (rst),
      .i_lookup_tag (inst_addr[63:3]),
      .o_hit        (w_lb_hit),
      .o_data       (w_lb_data),
      .i_fill       (w_done_rd && !w_err_tot),
      .i_fill_tag   (r_addr[63:3]),
      .i_fill_data  (axi_r_data),
      .i_inval      ((w_done_rd && w_err_tot) || w_mis_accept)
   );
`else
   assign w_lb_hit  = 1'b0;
   assign w_lb_data = 64'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (if_valid) begin
               if (w_misaligned || w_lb_hit) w_state_nxt = S_RESP;
               else                          w_state_nxt = S_AR;
            end
         end
         S_AR:    if (axi_ar_ready) w_state_nxt = S_R;
         S_R:     if (axi_r_valid && axi_r_last) w_state_nxt = S_RESP;
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs are registered copies of the state being entered.
   always_comb begin
      w_ar_valid_nxt = (w_state_nxt == S_AR);
      w_r_ready_nxt  = (w_state_nxt == S_R);
      w_if_ready_nxt = (w_state_nxt == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ar_valid <= 1'b0;
         r_r_ready  <= 1'b0;
         r_if_ready <= 1'b0;
         r_addr     <= '0;
         r_size     <= '0;
         r_err      <= 1'b0;
         r_if_data  <= '0;
         r_if_resp  <= RESP_OKAY;
      end else begin
         r_ar_valid <= w_ar_valid_nxt;
         r_r_ready  <= w_r_ready_nxt;
         r_if_ready <= w_if_ready_nxt;
         if (w_idle_req) begin
            r_addr <= inst_addr;
            r_size <= if_size;
            r_err  <= 1'b0;
         end
         if (w_mis_accept) begin
            r_if_data <= '0;
            r_if_resp <= RESP_SLVERR;
         end else if (w_hit_accept) begin
            r_if_data <= {32'd0, lane_sel(inst_addr[2], w_lb_data)};
            r_if_resp <= RESP_OKAY;
         end
         // Every beat overwrites the data; the error flag sticks until the last beat.
         if (w_beat) begin
            r_if_data <= {32'd0, lane_sel(r_addr[2], axi_r_data)};
            r_err     <= w_err_tot;
            if (axi_r_last) r_if_resp <= w_err_tot ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign if_ready     = r_if_ready;
   assign if_data_read = r_if_data;
   assign if_resp      = r_if_resp;
   assign axi_ar_valid = r_ar_valid;
   assign axi_ar_addr  = r_addr;
   assign axi_ar_id    = AXI_ID;
   assign axi_ar_len   = 8'd0;
   assign axi_ar_size  = {1'b0, r_size};
   assign axi_ar_burst = BURST_INCR;
   assign axi_r_ready  = r_r_ready;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040759_if_axi_bridge.sv
// ============================================================================
// Module : tb_ysyx_22040759_if_axi_bridge
// Brief  : Directed table-driven bench for the IF-to-AXI fetch bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22040759_if_axi_bridge;
   import ysyx_22040759_if_axi_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [63:0] inst_addr;
   logic [1:0]  if_size;
   logic        if_ready;
   logic [63:0] if_data_read;
   logic [1:0]  if_resp;
   logic        axi_ar_valid;
   logic        axi_ar_ready;
   logic [63:0] axi_ar_addr;
   logic [3:0]  axi_ar_id;
   logic [7:0]  axi_ar_len;
   logic [2:0]  axi_ar_size;
   logic [1:0]  axi_ar_burst;
   logic        axi_r_valid;
   logic        axi_r_ready;
   logic [63:0] axi_r_data;
   logic [1:0]  axi_r_resp;
   logic        axi_r_last;
   logic [3:0]  axi_r_id;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22040759_if_axi_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .inst_addr(inst_addr), .if_size(if_size),
      .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
      .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
      .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
      .axi_ar_burst(axi_ar_burst),
      .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
      .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
   );

   typedef struct {
      logic [63:0] addr;
      int          ar_dly;
      logic [63:0] rdata;
      logic [1:0]  rresp;
      logic [3:0]  rid;
      int          nbeats;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      int          exp_lat;
      int          exp_ar;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Issue one fetch while acting as the AXI slave, then check the completion.
   task automatic fetch(input string tag, input vec_t v);
      int  cycles = 0;
      int  ar_obs = 0;
      int  beats = 0;
      bit  ar_bad = 0;
      bit  done = 0;
      bit  rr_prev = 0;
      bit  rv_drv = 0;
      logic [63:0] got_data;
      logic [1:0]  got_resp;
      @(negedge clk);
      if_valid  = 1'b1;
      inst_addr = v.addr;
      if_size   = SIZE_W;
      while (!done && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
         if (rv_drv && rr_prev) beats++;
         if (axi_ar_valid) begin
            ar_obs++;
            if (axi_ar_addr !== v.addr || axi_ar_size !== 3'b010 || axi_ar_len !== 8'd0 ||
                axi_ar_burst !== 2'b01 || axi_ar_id !== 4'd0) ar_bad = 1;
         end
         axi_ar_ready = axi_ar_valid && (ar_obs > v.ar_dly);
         if (if_ready) begin
            done     = 1;
            got_data = if_data_read;
            got_resp = if_resp;
            if_valid = 1'b0;
         end
         rr_prev = axi_r_ready;
         if (axi_r_ready && beats < v.nbeats) begin
            axi_r_valid = 1'b1;
            axi_r_last  = (beats == v.nbeats - 1);
            axi_r_data  = v.rdata;
            axi_r_resp  = v.rresp;
            axi_r_id    = v.rid;
         end else begin
            axi_r_valid = 1'b0;
            axi_r_last  = 1'b0;
         end
         rv_drv = axi_r_valid;
      end
      if_valid     = 1'b0;
      axi_ar_ready = 1'b0;
      axi_r_valid  = 1'b0;
      axi_r_last   = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no if_ready required=if_ready", tag);
      end else begin
         chk({tag, " data"}, got_data, {32'd0, v.exp_data});
         chk({tag, " resp"}, {62'd0, got_resp}, {62'd0, v.exp_resp});
         chk({tag, " latency"}, 64'(cycles), 64'(v.exp_lat));
         chk({tag, " ar_cycles"}, 64'(ar_obs), 64'(v.exp_ar));
         chk({tag, " ar_stable"}, {63'd0, ar_bad}, 64'd0);
         chk({tag, " beats"}, 64'(beats), 64'((v.exp_ar == 0) ? 0 : v.nbeats));
         @(posedge clk); #1;
         chk({tag, " pulse_end"}, {63'd0, if_ready}, 64'd0);
      end
   endtask

   vec_t vecs[7];

   initial begin
      int n;
      rst = 1'b1; if_valid = 1'b0; inst_addr = '0; if_size = SIZE_W;
      axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = '0;
      axi_r_resp = 2'b00; axi_r_last = 1'b0; axi_r_id = 4'd0;

      vecs[0] = '{64'h8000_0000, 0, 64'h00100073_00000413, 2'b00, 4'd0, 1, 32'h00000413, 2'b00, 3, 1};
      vecs[1] = '{64'h8000_0100, 0, 64'hDEADBEEF_CAFEF00D, 2'b10, 4'd0, 1, 32'hCAFEF00D, 2'b10, 3, 1};
      vecs[2] = '{64'h8000_0004, 4, 64'h00100073_00000413, 2'b00, 4'd0, 1, 32'h00100073, 2'b00, 7, 5};
      vecs[3] = '{64'h8000_0200, 0, 64'h11112222_33334444, 2'b00, 4'd1, 1, 32'h33334444, 2'b10, 3, 1};
      vecs[4] = '{64'h8000_030C, 0, 64'hAAAABBBB_CCCCDDDD, 2'b00, 4'd0, 2, 32'hAAAABBBB, 2'b10, 4, 1};
      vecs[5] = '{64'h8000_0002, 0, 64'h0,                 2'b00, 4'd0, 1, 32'h00000000, 2'b10, 1, 0};
      vecs[6] = '{64'h8000_0410, 2, 64'h12345678_9ABCDEF0, 2'b00, 4'd0, 1, 32'h9ABCDEF0, 2'b00, 5, 3};

      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      chk("rst if_ready", {63'd0, if_ready}, 64'd0);
      chk("rst ar_valid", {63'd0, axi_ar_valid}, 64'd0);
      chk("rst r_ready", {63'd0, axi_r_ready}, 64'd0);
      chk("rst data", if_data_read, 64'd0);
      chk("rst resp", {62'd0, if_resp}, 64'd0);

      // Reset while waiting in R with r_valid held low.
      if_valid = 1'b1; inst_addr = 64'h8000_0040; axi_ar_ready = 1'b1;
      n = 0;
      while (!axi_r_ready && n < 10) begin
         @(posedge clk); #1; n++;
      end
      chk("midrst reached_R", {63'd0, axi_r_ready}, 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1; if_valid = 1'b0; axi_ar_ready = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst r_ready", {63'd0, axi_r_ready}, 64'd0);
      chk("midrst ar_valid", {63'd0, axi_ar_valid}, 64'd0);
      chk("midrst if_ready", {63'd0, if_ready}, 64'd0);

      for (int i = 0; i < 7; i++) fetch($sformatf("vec%0d", i), vecs[i]);

`ifdef YSYX_22040759_IFB_LINEBUF_EN
      begin
         vec_t lv;
         lv = '{64'h8000_0000, 0, 64'h00100073_00000413, 2'b00, 4'd0, 1, 32'h00000413, 2'b00, 3, 1};
         fetch("lb fill", lv);
         lv = '{64'h8000_0004, 0, 64'hFFFFFFFF_FFFFFFFF, 2'b00, 4'd0, 1, 32'h00100073, 2'b00, 1, 0};
         fetch("lb hit", lv);
         lv = '{64'h8000_0008, 0, 64'h55556666_77778888, 2'b00, 4'd0, 1, 32'h77778888, 2'b00, 3, 1};
         fetch("lb newline", lv);
         lv = '{64'h8000_0002, 0, 64'h0, 2'b00, 4'd0, 1, 32'h00000000, 2'b10, 1, 0};
         fetch("lb err", lv);
         lv = '{64'h8000_000C, 0, 64'h55556666_77778888, 2'b00, 4'd0, 1, 32'h55556666, 2'b00, 3, 1};
         fetch("lb miss_after_err", lv);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
